mem_access_initiator: RTL and testbench
=======================================

// Module: mem_access_initiator
// PURPOSE
//  MEM-stage load/store initiator: the requesting side of the data-memory access.
//  Takes one load/store per handshake from the pipeline and issues byte-wide
//  transactions on a valid/ack bus to the byte-addressed data memory.
//  Assembles load bytes little-endian and sign/zero-extends them per Variant (funct3).
//  Holds Stall high while an access is in flight.
// PARAMETERS
//  MEM_ADDR_BITS  7  byte-address width of data memory (128 B); addresses wrap mod 2^MEM_ADDR_BITS
// PORTS
//  Clk              in   1   clock, rising edge
//  Reset            in   1   asynchronous, active-high reset
//  Req_Valid        in   1   pipeline presents an access
//  Req_Ready        out  1   initiator idle, accepts request this cycle
//  Is_Load          in   1   access is a load
//  Is_Store         in   1   access is a store
//  Variant          in   3   funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  Mem_Address_Reg  in   32  byte address (low MEM_ADDR_BITS used)
//  Mem_Data_Reg     in   32  store data
//  Resp_Valid       out  1   one-cycle pulse: access complete
//  Access_Err       out  1   one-cycle pulse with Resp_Valid: illegal request
//  Loaded_Data_MEM  out  32  extended load result
//  Stall            out  1   access in flight
//  Bus_Req          out  1   byte transaction request
//  Bus_We           out  1   1 = write byte, 0 = read byte
//  Bus_Addr         out  MEM_ADDR_BITS  byte address
//  Bus_Wdata        out  8   write byte
//  Bus_Ack          in   1   memory completes the current byte at this rising edge
//  Bus_Rdata        in   8   read byte, valid when Bus_Ack=1
// BEHAVIOUR
//  Reset: FSM=IDLE. Req_Ready=1. Resp_Valid, Access_Err, Stall, Bus_Req, Bus_We = 0.
//   Bus_Addr, Bus_Wdata, Loaded_Data_MEM = 0.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//   Req_Ready = (state==IDLE). Stall = (state!=IDLE).
//  IDLE: on Req_Valid&Req_Ready, latch all request inputs. byte_idx=0. N = 1/2/4 for Variant[1:0] = 00/01/10.
//   Legal request -> ACCESS. Illegal request -> DONE with no bus activity.
//   Illegal = Is_Load==Is_Store, load Variant in {011,110,111}, or store Variant not in {000,001,010}.
//  ACCESS: Bus_Req=1. Bus_We=latched Is_Store.
//   Bus_Addr = (base + byte_idx) mod 2^MEM_ADDR_BITS. Bus_Wdata = store_data[8*byte_idx +: 8].
//   Bus outputs stay stable until Bus_Ack. On Bus_Ack: a load captures Bus_Rdata into byte byte_idx.
//   byte_idx++. After the Nth ack -> DONE.
//   Bus_Req may stay high back-to-back across bytes; address/data update in the cycle after each ack.
//   Bus_Ack is ignored when Bus_Req=0.
//  DONE (1 cycle): Resp_Valid=1. Access_Err=1 only for an illegal request. Then -> IDLE.
//   Loaded_Data_MEM updates at the DONE entry edge, legal loads only:
//    lb/lh sign-extend from bit 7/15. lbu/lhu zero-extend. lw is a direct copy.
//   Stores and illegal requests leave Loaded_Data_MEM unchanged. It holds until the next legal load.
//  Latency: with Bus_Ack tied 1, Resp_Valid is high in cycle accept+N+1.
//   For an illegal request, Resp_Valid is high in cycle accept+1.
//   A new request is accepted at the earliest in the cycle after DONE.
//  Misalignment is allowed. Addresses wrap: lw at 126 reads bytes 126,127,0,1.
//  Reset mid-access: abort immediately. Bus_Req drops asynchronously. No Resp_Valid.
//   Store bytes already acked remain written (no rollback).
// TESTING
//  T1: Memory model byte[a]=a, Ack tied 1, lw @4
//   -> Bus_Addr 4,5,6,7; Loaded_Data_MEM=32'h07060504; Resp_Valid at accept+5.
//  T2: byte[0x10]=8'h80, byte[0x11]=8'hFF
//   -> lb @0x10 = FFFFFF80; lbu = 00000080; lh = FFFFFF80; lhu = 0000FF80.
//  T3: sw 32'hDEADBEEF @126
//   -> writes 126=EF, 127=BE, 0=AD, 1=DE with Bus_We=1; Loaded_Data_MEM unchanged.
//  T4: sh @8, Ack withheld 3 cycles on byte 1
//   -> Bus_Addr=9 and Bus_Wdata stable throughout; Stall=1; Req_Ready=0; single Resp_Valid pulse after.
//  T5: Is_Load=Is_Store=1 (also load Variant 011)
//   -> no Bus_Req; Resp_Valid and Access_Err high together at accept+1 for exactly 1 cycle.
//  T6: Reset asserted after 2 acks of an lw
//   -> Bus_Req=0 the same cycle; no Resp_Valid; Req_Ready=1; Loaded_Data_MEM=0.

Source files
------------

// File: rtl/mem_access_initiator_if.sv
// Pipeline request/response and byte-wide memory bus bundle for the MEM-stage load/store initiator.
interface mem_access_initiator_if #(
   parameter int unsigned MEM_ADDR_BITS = 7
);
   logic                     Req_Valid;
   logic                     Req_Ready;
   logic                     Is_Load;
   logic                     Is_Store;
   logic [2:0]               Variant;
   logic [31:0]              Mem_Address_Reg;
   logic [31:0]              Mem_Data_Reg;
   logic                     Resp_Valid;
   logic                     Access_Err;
   logic [31:0]              Loaded_Data_MEM;
   logic                     Stall;
   logic                     Bus_Req;
   logic                     Bus_We;
   logic [MEM_ADDR_BITS-1:0] Bus_Addr;
   logic [7:0]               Bus_Wdata;
   logic                     Bus_Ack;
   logic [7:0]               Bus_Rdata;

   modport master (
      input  Req_Valid, Is_Load, Is_Store, Variant, Mem_Address_Reg, Mem_Data_Reg,
      input  Bus_Ack, Bus_Rdata,
      output Req_Ready, Resp_Valid, Access_Err, Loaded_Data_MEM, Stall,
      output Bus_Req, Bus_We, Bus_Addr, Bus_Wdata
   );

   modport slave (
      output Req_Valid, Is_Load, Is_Store, Variant, Mem_Address_Reg, Mem_Data_Reg,
      output Bus_Ack, Bus_Rdata,
      input  Req_Ready, Resp_Valid, Access_Err, Loaded_Data_MEM, Stall,
      input  Bus_Req, Bus_We, Bus_Addr, Bus_Wdata
   );
endinterface

// File: rtl/mem_access_initiator.sv
// MEM-stage load/store initiator: splits one pipeline access into 1/2/4 byte transactions
// on a valid/ack bus and returns the extended load result.
module mem_access_initiator #(
   parameter int unsigned MEM_ADDR_BITS = 7
) (
   input  logic                  Clk,
   input  logic                  Reset,
   mem_access_initiator_if.master bus
);
   localparam int unsigned AW = MEM_ADDR_BITS;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   state_e          state_q, state_d;
   logic            req_ready_q, req_ready_d;
   logic            stall_q, stall_d;
   logic            resp_valid_q, resp_valid_d;
   logic            access_err_q, access_err_d;
   logic            bus_req_q, bus_req_d;
   logic            bus_we_q, bus_we_d;
   logic [AW-1:0]   bus_addr_q, bus_addr_d;
   logic [7:0]      bus_wdata_q, bus_wdata_d;
   logic [31:0]     loaded_q, loaded_d;
   logic [AW-1:0]   base_q, base_d;
   logic [31:0]     sdata_q, sdata_d;
   logic [31:0]     rbuf_q, rbuf_d;
   logic [2:0]      variant_q, variant_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [1:0]      last_idx_q, last_idx_d;

   logic            illegal_c;
   logic [1:0]      nidx_c;
   logic [31:0]     asm_c;
   logic [31:0]     ext_c;

   // Request legality and load-result assembly/extension.
   always_comb begin
      illegal_c = (bus.Is_Load == bus.Is_Store)
               || (bus.Is_Load  && ((bus.Variant == 3'b011) || (bus.Variant[2:1] == 2'b11)))
               || (bus.Is_Store && (bus.Variant[2] || (bus.Variant[1:0] == 2'b11)));
      nidx_c = byte_idx_q + 2'd1;
      asm_c  = rbuf_q;
      asm_c[{byte_idx_q, 3'b000} +: 8] = bus.Bus_Rdata;
      case (variant_q)
         3'b000:  ext_c = {{24{asm_c[7]}}, asm_c[7:0]};
         3'b001:  ext_c = {{16{asm_c[15]}}, asm_c[15:0]};
         3'b100:  ext_c = {24'd0, asm_c[7:0]};
         3'b101:  ext_c = {16'd0, asm_c[15:0]};
         default: ext_c = asm_c;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      stall_d      = stall_q;
      resp_valid_d = 1'b0;
      access_err_d = 1'b0;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      loaded_d     = loaded_q;
      base_d       = base_q;
      sdata_d      = sdata_q;
      rbuf_d       = rbuf_q;
      variant_d    = variant_q;
      byte_idx_d   = byte_idx_q;
      last_idx_d   = last_idx_q;

      unique case (state_q)
         IDLE: begin
            if (bus.Req_Valid) begin
               base_d      = bus.Mem_Address_Reg[AW-1:0];
               sdata_d     = bus.Mem_Data_Reg;
               variant_d   = bus.Variant;
               rbuf_d      = 32'd0;
               byte_idx_d  = 2'd0;
               last_idx_d  = (bus.Variant[1:0] == 2'b00) ? 2'd0 :
                             (bus.Variant[1:0] == 2'b01) ? 2'd1 : 2'd3;
               req_ready_d = 1'b0;
               stall_d     = 1'b1;
               if (illegal_c) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  access_err_d = 1'b1;
               end else begin
                  state_d     = ACCESS;
                  bus_req_d   = 1'b1;
                  bus_we_d    = bus.Is_Store;
                  bus_addr_d  = bus.Mem_Address_Reg[AW-1:0];
                  bus_wdata_d = bus.Mem_Data_Reg[7:0];
               end
            end
         end
         ACCESS: begin
            if (bus.Bus_Ack) begin
               rbuf_d = asm_c;
               if (byte_idx_q == last_idx_q) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  bus_req_d    = 1'b0;
                  bus_we_d     = 1'b0;
                  if (!bus_we_q) loaded_d = ext_c;
               end else begin
                  byte_idx_d  = nidx_c;
                  bus_addr_d  = AW'(base_q + AW'(nidx_c));
                  bus_wdata_d = sdata_q[{nidx_c, 3'b000} +: 8];
               end
            end
         end
         DONE: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            stall_d     = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Async reset also aborts any in-flight access and drops Bus_Req at once.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         stall_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         access_err_q <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= 8'd0;
         loaded_q     <= 32'd0;
         base_q       <= '0;
         sdata_q      <= 32'd0;
         rbuf_q       <= 32'd0;
         variant_q    <= 3'd0;
         byte_idx_q   <= 2'd0;
         last_idx_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         stall_q      <= stall_d;
         resp_valid_q <= resp_valid_d;
         access_err_q <= access_err_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         loaded_q     <= loaded_d;
         base_q       <= base_d;
         sdata_q      <= sdata_d;
         rbuf_q       <= rbuf_d;
         variant_q    <= variant_d;
         byte_idx_q   <= byte_idx_d;
         last_idx_q   <= last_idx_d;
      end
   end

   assign bus.Req_Ready       = req_ready_q;
   assign bus.Stall           = stall_q;
   assign bus.Resp_Valid      = resp_valid_q;
   assign bus.Access_Err      = access_err_q;
   assign bus.Bus_Req         = bus_req_q;
   assign bus.Bus_We          = bus_we_q;
   assign bus.Bus_Addr        = bus_addr_q;
   assign bus.Bus_Wdata       = bus_wdata_q;
   assign bus.Loaded_Data_MEM = loaded_q;
endmodule

// File: tb/tb_mem_access_initiator.sv
// Randomized bench for mem_access_initiator against a byte-array memory and reference model.
module tb_mem_access_initiator;
   localparam int unsigned AW = 7;

   typedef struct packed {
      logic       we;
      logic [6:0] addr;
      logic [7:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_initiator_if #(.MEM_ADDR_BITS(AW)) bus ();
   mem_access_initiator #(.MEM_ADDR_BITS(AW)) dut (.Clk(clk), .Reset(rst), .bus(bus));

   logic [7:0]  mem     [128];
   logic [7:0]  ref_mem [128];
   txn_t        obs_q [$];
   int          ack_mode  = 0;
   logic        ack_force = 1'b1;
   int          checks    = 0;
   int          failures  = 0;
   logic [31:0] exp_loaded;

   logic        cur_ld, cur_st;
   logic [2:0]  cur_v;
   logic [31:0] cur_a, cur_d;

   assign bus.Bus_Rdata = mem[bus.Bus_Addr];

   // Memory responder: 0 = ack every cycle, 1 = random ack, 2 = bench-controlled ack.
   always @(negedge clk) begin
      case (ack_mode)
         0:       bus.Bus_Ack = 1'b1;
         1:       bus.Bus_Ack = 1'($urandom_range(0, 1));
         default: bus.Bus_Ack = ack_force;
      endcase
   end

   always @(posedge clk) begin
      if (!rst && bus.Bus_Req && bus.Bus_Ack) begin
         obs_q.push_back('{we: bus.Bus_We, addr: bus.Bus_Addr, wdata: bus.Bus_Wdata});
         if (bus.Bus_We) mem[bus.Bus_Addr] = bus.Bus_Wdata;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int n_bytes(input logic [2:0] v);
      return (v[1:0] == 2'b00) ? 1 : (v[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_illegal(input logic ld, input logic st, input logic [2:0] v);
      if (ld == st) return 1'b1;
      if (ld) return (v == 3'd3) || (v == 3'd6) || (v == 3'd7);
      return !((v == 3'd0) || (v == 3'd1) || (v == 3'd2));
   endfunction

   function automatic int wrap(input logic [31:0] a, input int i);
      return int'((a + 32'(i)) % 128);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] v);
      logic [31:0] raw = 32'd0;
      for (int i = 0; i < n_bytes(v); i++) raw[8*i +: 8] = ref_mem[wrap(a, i)];
      case (v)
         3'd0:    return {{24{raw[7]}}, raw[7:0]};
         3'd1:    return {{16{raw[15]}}, raw[15:0]};
         3'd4:    return {24'd0, raw[7:0]};
         3'd5:    return {16'd0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   // Presents one request at a falling edge and returns just after the accepting edge.
   task automatic begin_op(input logic ld, input logic st, input logic [2:0] v,
                           input logic [31:0] a, input logic [31:0] d, input int mode);
      cur_ld = ld; cur_st = st; cur_v = v; cur_a = a; cur_d = d;
      ack_mode = mode;
      obs_q.delete();
      check_eq("req_ready_idle", 32'(bus.Req_Ready), 32'd1);
      bus.Req_Valid = 1'b1; bus.Is_Load = ld; bus.Is_Store = st;
      bus.Variant = v; bus.Mem_Address_Reg = a; bus.Mem_Data_Reg = d;
      @(posedge clk);
      #1 bus.Req_Valid = 1'b0;
   endtask

   task automatic end_op(input bit lat_chk);
      bit ill = is_illegal(cur_ld, cur_st, cur_v);
      int n   = n_bytes(cur_v);
      int cyc = 1;
      @(negedge clk);
      check_eq("stall_busy", 32'(bus.Stall), 32'd1);
      while (!bus.Resp_Valid && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("resp_valid", 32'(bus.Resp_Valid), 32'd1);
      check_eq("access_err", 32'(bus.Access_Err), 32'(ill));
      if (lat_chk) check_eq("latency", 32'(cyc), ill ? 32'd1 : 32'(n + 1));
      if (!ill) begin
         for (int i = 0; i < n; i++)
            if (cur_st) ref_mem[wrap(cur_a, i)] = cur_d[8*i +: 8];
         if (cur_ld) exp_loaded = ref_load(cur_a, cur_v);
      end
      check_eq("txn_count", 32'(obs_q.size()), ill ? 32'd0 : 32'(n));
      for (int i = 0; i < obs_q.size() && i < n && !ill; i++) begin
         check_eq("txn_we", 32'(obs_q[i].we), 32'(cur_st));
         check_eq("txn_addr", 32'(obs_q[i].addr), 32'(wrap(cur_a, i)));
         if (cur_st) check_eq("txn_wdata", 32'(obs_q[i].wdata), 32'(cur_d[8*i +: 8]));
      end
      check_eq("loaded_data", bus.Loaded_Data_MEM, exp_loaded);
      @(negedge clk);
      check_eq("resp_pulse_end", 32'(bus.Resp_Valid), 32'd0);
      check_eq("err_pulse_end", 32'(bus.Access_Err), 32'd0);
   endtask

   task automatic do_op(input logic ld, input logic st, input logic [2:0] v,
                        input logic [31:0] a, input logic [31:0] d, input int mode);
      begin_op(ld, st, v, a, d, mode);
      end_op(mode == 0);
   endtask

   initial begin
      int diffs;
      bus.Req_Valid = 1'b0; bus.Is_Load = 1'b0; bus.Is_Store = 1'b0;
      bus.Variant = 3'd0; bus.Mem_Address_Reg = 32'd0; bus.Mem_Data_Reg = 32'd0;
      for (int i = 0; i < 128; i++) begin
         mem[i] = 8'(i);
         ref_mem[i] = 8'(i);
      end
      exp_loaded = 32'd0;
      repeat (2) @(negedge clk);
      check_eq("rst_req_ready", 32'(bus.Req_Ready), 32'd1);
      check_eq("rst_resp_valid", 32'(bus.Resp_Valid), 32'd0);
      check_eq("rst_access_err", 32'(bus.Access_Err), 32'd0);
      check_eq("rst_stall", 32'(bus.Stall), 32'd0);
      check_eq("rst_bus_req", 32'(bus.Bus_Req), 32'd0);
      check_eq("rst_bus_we", 32'(bus.Bus_We), 32'd0);
      check_eq("rst_bus_addr", 32'(bus.Bus_Addr), 32'd0);
      check_eq("rst_bus_wdata", 32'(bus.Bus_Wdata), 32'd0);
      check_eq("rst_loaded", bus.Loaded_Data_MEM, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_op(1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 0);
      check_eq("t1_lw", bus.Loaded_Data_MEM, 32'h0706_0504);

      mem[16] = 8'h80; ref_mem[16] = 8'h80;
      mem[17] = 8'hFF; ref_mem[17] = 8'hFF;
      do_op(1'b1, 1'b0, 3'b000, 32'h10, 32'd0, 0);
      check_eq("t2_lb", bus.Loaded_Data_MEM, 32'hFFFF_FF80);
      do_op(1'b1, 1'b0, 3'b100, 32'h10, 32'd0, 0);
      check_eq("t2_lbu", bus.Loaded_Data_MEM, 32'h0000_0080);
      do_op(1'b1, 1'b0, 3'b001, 32'h10, 32'd0, 0);
      check_eq("t2_lh", bus.Loaded_Data_MEM, 32'hFFFF_FF80);
      do_op(1'b1, 1'b0, 3'b101, 32'h10, 32'd0, 0);
      check_eq("t2_lhu", bus.Loaded_Data_MEM, 32'h0000_FF80);

      do_op(1'b0, 1'b1, 3'b010, 32'd126, 32'hDEAD_BEEF, 0);
      check_eq("t3_m126", 32'(mem[126]), 32'hEF);
      check_eq("t3_m127", 32'(mem[127]), 32'hBE);
      check_eq("t3_m0", 32'(mem[0]), 32'hAD);
      check_eq("t3_m1", 32'(mem[1]), 32'hDE);
      check_eq("t3_loaded_kept", bus.Loaded_Data_MEM, 32'h0000_FF80);

      // Ack for the second halfword byte is withheld for three cycles.
      ack_force = 1'b1;
      begin_op(1'b0, 1'b1, 3'b001, 32'd8, 32'h1234_A5C3, 2);
      @(posedge clk);
      #1 ack_force = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("t4_addr", 32'(bus.Bus_Addr), 32'd9);
         check_eq("t4_wdata", 32'(bus.Bus_Wdata), 32'hA5);
         check_eq("t4_bus_req", 32'(bus.Bus_Req), 32'd1);
         check_eq("t4_bus_we", 32'(bus.Bus_We), 32'd1);
         check_eq("t4_stall", 32'(bus.Stall), 32'd1);
         check_eq("t4_req_ready", 32'(bus.Req_Ready), 32'd0);
         check_eq("t4_no_resp", 32'(bus.Resp_Valid), 32'd0);
      end
      @(posedge clk);
      #1 ack_force = 1'b1;
      end_op(1'b0);

      do_op(1'b1, 1'b1, 3'b010, 32'd20, 32'd0, 0);
      do_op(1'b1, 1'b0, 3'b011, 32'd20, 32'd0, 0);
      do_op(1'b1, 1'b0, 3'b110, 32'd20, 32'd0, 0);
      do_op(1'b0, 1'b1, 3'b100, 32'd20, 32'd0, 0);
      do_op(1'b0, 1'b0, 3'b000, 32'd20, 32'd0, 0);

      for (int k = 0; k < 80; k++) begin
         int r = int'($urandom_range(0, 9));
         logic ld = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         logic st = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : !ld;
         logic [31:0] a = ($urandom_range(0, 3) == 0) ? (32'd124 + 32'($urandom_range(0, 3)))
                                                      : $urandom;
         do_op(ld, st, 3'($urandom_range(0, 7)), a, $urandom, int'($urandom_range(0, 1)));
      end
      diffs = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check_eq("mem_image_diffs", 32'(diffs), 32'd0);

      // Reset lands after the second of four load acks.
      begin_op(1'b1, 1'b0, 3'b010, 32'd20, 32'd0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      exp_loaded = 32'd0;
      check_eq("t6_bus_req", 32'(bus.Bus_Req), 32'd0);
      check_eq("t6_req_ready", 32'(bus.Req_Ready), 32'd1);
      check_eq("t6_stall", 32'(bus.Stall), 32'd0);
      check_eq("t6_resp", 32'(bus.Resp_Valid), 32'd0);
      check_eq("t6_loaded", bus.Loaded_Data_MEM, 32'd0);
      check_eq("t6_acks_seen", 32'(obs_q.size()), 32'd2);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("t6_resp_after", 32'(bus.Resp_Valid), 32'd0);
      do_op(1'b1, 1'b0, 3'b100, 32'd21, 32'd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
